// File: rtl/step_dir_pkg.sv
// step_dir_pkg: shared types and helpers for the step/direction decoder.
//   state_e   : decoder motion state
//   DEF_*     : default parameter values
//   sat_inc32 : 32-bit increment that sticks at all-ones
package step_dir_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_RUN} state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_MIN_PULSE   = 4;
  localparam int unsigned DEF_TIMEOUT     = 5_000_000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/step_input_sync.sv
// step_input_sync: multi-flop synchronizer with rise/fall detect.
//   clk, reset : clock, synchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronized level
//   rise_o     : 1-cycle pulse on synchronized 0->1
//   fall_o     : 1-cycle pulse on synchronized 1->0
//   valid_o    : q_o reflects a real input sample (pipeline filled since reset)
module step_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic valid_o
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      // Tracks how far the first post-reset sample has travelled, so the
      // reset value of the flops is never mistaken for a real low level.
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o     = sync_q[STAGES-1];
  assign rise_o  = q_o & ~prev_q;
  assign fall_o  = ~q_o & prev_q;
  assign valid_o = fill_q[STAGES-1];
endmodule

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: decodes a STEP/DIR pair into position, step count and
// step period; flags short STEP pulses and overspeed.
//   clk, reset      : clock, synchronous active-high reset
//   step_in, dir_in : asynchronous STEP (rise = step) and DIR (0 = positive)
//   dir_inversion   : flips the direction sense
//   clear_pos       : zero position and step_count
//   err_clear       : clear sticky errors
//   min_period      : overspeed threshold in clk cycles, 0 disables
//   step_strobe     : 1-cycle pulse per accepted step
//   position        : signed position
//   step_count      : saturating accepted-step count
//   period/period_valid : last rise-to-rise interval and its update pulse
//   moving          : state is FIRST or RUN
//   glitch_err, overspeed_err : sticky error flags
module step_dir_decoder
  import step_dir_pkg::*;
#(
  parameter int POS_W       = 32,
  parameter int PERIOD_W    = 32,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    dir_inversion,
  input  logic                    clear_pos,
  input  logic                    err_clear,
  input  logic [PERIOD_W-1:0]     min_period,
  output logic                    step_strobe,
  output logic signed [POS_W-1:0] position,
  output logic [31:0]             step_count,
  output logic [PERIOD_W-1:0]     period,
  output logic                    period_valid,
  output logic                    moving,
  output logic                    glitch_err,
  output logic                    overspeed_err
);
  localparam int HW = $clog2(MIN_PULSE + 1);

  logic step_q, step_rise, step_fall, step_valid;
  logic dir_q, dir_rise_unused, dir_fall_unused, dir_valid_unused;

  step_input_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk(clk), .reset(reset), .d_i(step_in),
    .q_o(step_q), .rise_o(step_rise), .fall_o(step_fall), .valid_o(step_valid));

  step_input_sync #(.STAGES(SYNC_STAGES)) u_dir_sync (
    .clk(clk), .reset(reset), .d_i(dir_in),
    .q_o(dir_q), .rise_o(dir_rise_unused), .fall_o(dir_fall_unused),
    .valid_o(dir_valid_unused));

  state_e                    state_q, state_d;
  logic                      armed_q, pend_q, dir_eff_q;
  logic [HW-1:0]             cnt_q;
  logic [PERIOD_W-1:0]       per_cnt_q, per_cnt_d;
  logic signed [POS_W-1:0]   pos_q, pos_d, pos_base;
  logic [31:0]               cnt_steps_q, cnt_steps_d;
  logic [PERIOD_W-1:0]       period_q;
  logic                      strobe_q, pv_q, glitch_q, ovs_q;

  logic          rise_ok, accept, dir_use, new_period;
  logic [HW-1:0] cur;

  always_comb begin
    rise_ok  = step_rise & armed_q;
    // Number of consecutive high cycles including the current one.
    cur      = rise_ok ? HW'(1) : cnt_q + HW'(1);
    accept   = step_q & (rise_ok | pend_q) & (cur == HW'(MIN_PULSE));
    dir_use  = rise_ok ? (dir_q ^ dir_inversion) : dir_eff_q;
    new_period = accept & (state_q != ST_IDLE);

    // The accept cycle is the first cycle of the next interval.
    per_cnt_d = accept ? PERIOD_W'(1)
              : ((&per_cnt_q) ? per_cnt_q : per_cnt_q + PERIOD_W'(1));

    // clear_pos is applied before a coincident step.
    pos_base    = clear_pos ? '0 : pos_q;
    pos_d       = pos_base;
    cnt_steps_d = clear_pos ? 32'd0 : cnt_steps_q;
    if (accept) begin
      pos_d       = dir_use ? pos_base - POS_W'(1) : pos_base + POS_W'(1);
      cnt_steps_d = sat_inc32(cnt_steps_d);
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FIRST;
      ST_FIRST, ST_RUN: begin
        if (accept)                                 state_d = ST_RUN;
        else if (per_cnt_q == PERIOD_W'(TIMEOUT))   state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      dir_eff_q   <= 1'b0;
      cnt_q       <= '0;
      per_cnt_q   <= '0;
      pos_q       <= '0;
      cnt_steps_q <= '0;
      period_q    <= '0;
      strobe_q    <= 1'b0;
      pv_q        <= 1'b0;
      glitch_q    <= 1'b0;
      ovs_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Arm only once a genuine low has been seen, so a STEP held high
      // through reset is not counted.
      if (step_valid && !step_q) armed_q <= 1'b1;
      if (rise_ok) dir_eff_q <= dir_q ^ dir_inversion;
      if (accept) begin
        pend_q <= 1'b0;
      end else if (rise_ok) begin
        pend_q <= 1'b1;
        cnt_q  <= cur;
      end else if (pend_q && step_q) begin
        cnt_q  <= cur;
      end else if (step_fall) begin
        pend_q <= 1'b0;
      end
      per_cnt_q   <= per_cnt_d;
      pos_q       <= pos_d;
      cnt_steps_q <= cnt_steps_d;
      strobe_q    <= accept;
      pv_q        <= new_period;
      if (new_period) period_q <= per_cnt_q;
      glitch_q <= (glitch_q & ~err_clear) | (step_fall & pend_q);
      ovs_q    <= (ovs_q & ~err_clear)
                | (new_period && (min_period != '0) && (per_cnt_q < min_period));
    end
  end

  assign step_strobe   = strobe_q;
  assign position      = pos_q;
  assign step_count    = cnt_steps_q;
  assign period        = period_q;
  assign period_valid  = pv_q;
  assign moving        = (state_q != ST_IDLE);
  assign glitch_err    = glitch_q;
  assign overspeed_err = ovs_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
module tb_step_dir_decoder;
  logic clk = 1'b0, reset = 1'b1, step_in = 1'b0, dir_in = 1'b0;
  logic dir_inversion = 1'b0, clear_pos = 1'b0, err_clear = 1'b0;
  logic [31:0] min_period = '0;

  logic        step_strobe, period_valid, moving, glitch_err, overspeed_err;
  logic signed [31:0] position;
  logic [31:0] step_count, period;

  logic        step_strobe2, period_valid2, moving2, glitch_err2, overspeed_err2;
  logic signed [2:0]  position2;
  logic [31:0] step_count2, period2;

  step_dir_decoder #(.POS_W(32), .PERIOD_W(32), .SYNC_STAGES(2), .MIN_PULSE(4),
                     .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .dir_inversion(dir_inversion), .clear_pos(clear_pos), .err_clear(err_clear),
    .min_period(min_period), .step_strobe(step_strobe), .position(position),
    .step_count(step_count), .period(period), .period_valid(period_valid),
    .moving(moving), .glitch_err(glitch_err), .overspeed_err(overspeed_err));

  // Narrow position accumulator to exercise two's-complement wrap.
  step_dir_decoder #(.POS_W(3), .PERIOD_W(32), .SYNC_STAGES(2), .MIN_PULSE(4),
                     .TIMEOUT(1000)) dut_w (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .dir_inversion(dir_inversion), .clear_pos(clear_pos), .err_clear(err_clear),
    .min_period(min_period), .step_strobe(step_strobe2), .position(position2),
    .step_count(step_count2), .period(period2), .period_valid(period_valid2),
    .moving(moving2), .glitch_err(glitch_err2), .overspeed_err(overspeed_err2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int sc = 0, pv = 0, lat_bad = 0, lat_last = 0, per_bad = 0, rise_cyc = 0;
  logic chk_per = 1'b0, last_ovs = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (step_strobe) begin
        sc       <= sc + 1;
        lat_last <= cyc - rise_cyc;
        if (cyc - rise_cyc != 6) lat_bad <= lat_bad + 1;
      end
      if (period_valid) begin
        pv       <= pv + 1;
        last_ovs <= overspeed_err;
        if (chk_per && period != 32'd48) per_bad <= per_bad + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    rise_cyc = cyc;
    step_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 step_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clear_pos = 1'b1;
    @(posedge clk);
    #1 clear_pos = 1'b0;
  endtask

  // 8-high pulse with clear_pos on the accept cycle (rise + 6 edges).
  task automatic pulse_with_clear();
    rise_cyc = cyc;
    step_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 clear_pos = 1'b1;
    @(posedge clk);
    #1 clear_pos = 1'b0;
    repeat (2) @(posedge clk);
    #1 step_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  int s0, p0;

  initial begin
    // Reset state
    do_reset();
    chk("rst_pos", {32'd0, position}, 64'd0);
    chk("rst_cnt", step_count, 0);
    chk("rst_per", period, 0);
    chk("rst_moving", moving, 0);
    chk("rst_glitch", glitch_err, 0);
    chk("rst_ovs", overspeed_err, 0);

    // 1: ten forward steps, 48-cycle period
    s0 = sc; p0 = pv; chk_per = 1'b1;
    for (int i = 0; i < 10; i++) pulse(8, 40);
    chk_per = 1'b0;
    chk("t1_pos", {32'd0, position}, 64'd10);
    chk("t1_cnt", step_count, 10);
    chk("t1_strobes", sc - s0, 10);
    chk("t1_pv", pv - p0, 9);
    chk("t1_per_bad", per_bad, 0);
    chk("t1_period", period, 48);
    chk("t1_lat_bad", lat_bad, 0);
    chk("t1_lat", lat_last, 6);
    chk("t1_moving", moving, 1);

    // 2: reverse, then reverse with inversion
    dir_in = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) pulse(8, 40);
    chk("t2_pos_neg", {32'd0, position}, 64'hFFFF_FFF6);
    chk("t2_cnt", step_count, 10);
    clr_pulse();
    dir_inversion = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) pulse(8, 40);
    chk("t2_pos_inv", {32'd0, position}, 64'd10);
    dir_in = 1'b0; dir_inversion = 1'b0;

    // 3: glitch
    do_reset();
    s0 = sc;
    pulse(2, 40);
    chk("t3_strobes", sc - s0, 0);
    chk("t3_pos", {32'd0, position}, 64'd0);
    chk("t3_glitch", glitch_err, 1);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    chk("t3_glitch_clr", glitch_err, 0);

    // 4: overspeed
    min_period = 32'd50;
    do_reset();
    pulse(8, 40);
    chk("t4_ovs_first", overspeed_err, 0);
    pulse(8, 40);
    chk("t4_ovs_set", overspeed_err, 1);
    chk("t4_ovs_at_pv", last_ovs, 1);
    min_period = 32'd48;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(8, 40);
    chk("t4_ovs_eq", overspeed_err, 0);
    min_period = 32'd0;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(8, 40);
    chk("t4_ovs_off", overspeed_err, 0);

    // 5: timeout, restart without period, held-high across reset
    do_reset();
    pulse(8, 40);
    chk("t5_moving", moving, 1);
    repeat (1000) @(posedge clk);
    #1;
    chk("t5_idle", moving, 0);
    p0 = pv;
    pulse(8, 40);
    chk("t5_no_pv", pv - p0, 0);
    chk("t5_moving2", moving, 1);
    step_in = 1'b1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    s0 = sc;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_held_strobes", sc - s0, 0);
    chk("t5_held_cnt", step_count, 0);
    step_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    pulse(8, 40);
    chk("t5_rerise_cnt", step_count, 1);

    // 6: clear coincident with accept, wrap at max
    do_reset();
    for (int i = 0; i < 3; i++) pulse(8, 40);
    chk("t6_w_max", {61'd0, position2}, 64'd3);
    pulse(8, 40);
    chk("t6_w_wrap", {61'd0, position2}, 64'd4);
    chk("t6_pos4", {32'd0, position}, 64'd4);
    pulse_with_clear();
    chk("t6_clr_pos", {32'd0, position}, 64'd1);
    chk("t6_clr_cnt", step_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
